// File: rtl/td4_clock_controller.sv
// TD4 clock controller: turns the board clock into a one-cycle CPU clock-enable.
// Supports free-run (slow/fast), debounced single-step and a halt trap.
module td4_clock_controller #(
    parameter int unsigned CLOCK_HZ        = 100_000_000,
    parameter int unsigned SLOW_HZ         = 1,
    parameter int unsigned FAST_HZ         = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       run_switch,
    input  logic       step_button,
    input  logic       fast_select,
    input  logic       halt_in,
    output logic       cpu_tick,
    output logic       cpu_clock,
    output logic       running,
    output logic       trapped,
    output logic [7:0] tick_count
);

    localparam int unsigned SLOW_PERIOD = CLOCK_HZ / SLOW_HZ;
    localparam int unsigned FAST_PERIOD = CLOCK_HZ / FAST_HZ;
    localparam int unsigned CNT_W = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_PERIOD - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_PERIOD - 1);
    localparam logic [CNT_W-1:0] SLOW_HALF = CNT_W'(SLOW_PERIOD / 2);
    localparam logic [CNT_W-1:0] FAST_HALF = CNT_W'(FAST_PERIOD / 2);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP_HOLD,
        TRAP
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       meta_q, sync_q;
    logic             run_sync, step_sync, fast_sync, fast_change;
    logic             deb_q, deb_d, press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d, period_last, half_d;
    logic             terminal;
    logic             cpu_tick_q, cpu_tick_d;
    logic             cpu_clock_q, cpu_clock_d;
    logic             running_q, running_d;
    logic             trapped_q, trapped_d;
    logic [7:0]       tick_count_q, tick_count_d;

    assign run_sync    = sync_q[0];
    assign step_sync   = sync_q[1];
    assign fast_sync   = sync_q[2];
    // fast_sync is about to change: clear the divider on the same edge it does
    assign fast_change = meta_q[2] ^ sync_q[2];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {fast_select, step_button, run_switch};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press_d   = 1'b0;
        if (step_sync != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d   = step_sync;
                press_d = step_sync;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (halt_in)       state_d = TRAP;
                else if (run_sync) state_d = RUN;
                else if (press_q)  state_d = STEP_HOLD;
            end
            RUN: begin
                if (halt_in)        state_d = TRAP;
                else if (!run_sync) state_d = IDLE;
            end
            STEP_HOLD: begin
                if (!deb_q) state_d = IDLE;
            end
            TRAP: begin
                if (!run_sync && !deb_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign period_last = fast_sync ? FAST_LAST : SLOW_LAST;
    assign terminal    = (div_cnt_q == period_last);
    assign half_d      = meta_q[2] ? FAST_HALF : SLOW_HALF;

    always_comb begin
        cpu_tick_d = 1'b0;
        div_cnt_d  = '0;
        if (state_q == IDLE && state_d == STEP_HOLD) begin
            cpu_tick_d = 1'b1;
        end
        if (state_q == RUN && state_d == RUN) begin
            cpu_tick_d = terminal;
            if (!fast_change && !terminal) begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
        cpu_clock_d  = (state_d == STEP_HOLD) ||
                       (state_d == RUN && div_cnt_d < half_d);
        running_d    = (state_d == RUN);
        trapped_d    = (state_d == TRAP);
        tick_count_d = tick_count_q + 8'(cpu_tick_d);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            press_q      <= 1'b0;
            div_cnt_q    <= '0;
            cpu_tick_q   <= 1'b0;
            cpu_clock_q  <= 1'b0;
            running_q    <= 1'b0;
            trapped_q    <= 1'b0;
            tick_count_q <= '0;
        end else begin
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            press_q      <= press_d;
            div_cnt_q    <= div_cnt_d;
            cpu_tick_q   <= cpu_tick_d;
            cpu_clock_q  <= cpu_clock_d;
            running_q    <= running_d;
            trapped_q    <= trapped_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign cpu_tick   = cpu_tick_q;
    assign cpu_clock  = cpu_clock_q;
    assign running    = running_q;
    assign trapped    = trapped_q;
    assign tick_count = tick_count_q;

endmodule
